// File: rtl/gpio_filter_pkg.sv
// Shared defaults and per-pin state bundle for the GPIO input filter.
package gpio_filter_pkg;

  localparam int unsigned DefIOWidth  = 36;
  localparam int unsigned DefCntWidth = 8;
  // Counter field is sized for the widest supported CntWidth; channels zero-extend L.
  localparam int unsigned CntWidthMax = 16;

  typedef struct packed {
    logic                   sync;
    logic                   filtered;
    logic [CntWidthMax-1:0] cnt;
    logic                   rise;
    logic                   fall;
  } pin_state_t;

endpackage

// File: rtl/gpio_in_filter_if.sv
// Pad-side/register-side bundle for gpio_in_filter; master drives, slave is the filter.
interface gpio_in_filter_if
  import gpio_filter_pkg::*;
#(
  parameter int unsigned IOWidth  = DefIOWidth,
  parameter int unsigned CntWidth = DefCntWidth
);
  logic [IOWidth-1:0]  gpio_in_data;
  logic [IOWidth-1:0]  filt_en;
  logic [CntWidth-1:0] filt_len;
  logic [IOWidth-1:0]  flag_clr;
  logic [IOWidth-1:0]  filtered_data;
  logic [IOWidth-1:0]  rise_flags;
  logic [IOWidth-1:0]  fall_flags;

  modport master (
    output gpio_in_data, filt_en, filt_len, flag_clr,
    input  filtered_data, rise_flags, fall_flags
  );

  modport slave (
    input  gpio_in_data, filt_en, filt_len, flag_clr,
    output filtered_data, rise_flags, fall_flags
  );
endinterface

// File: rtl/gpio_filter_chan.sv
// One pin: sync flop, debounce counter, filtered flop and sticky edge flags.
// Edge flags exist only when GPIO_FILTER_EDGE_CAPTURE_EN is defined; otherwise tied to 0.
module gpio_filter_chan
  import gpio_filter_pkg::*;
#(
  parameter int unsigned CntWidth = DefCntWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                data_i,
  input  logic                en_i,
  input  logic [CntWidth-1:0] len_i,
  input  logic                clr_i,
  output logic                filtered_o,
  output logic                rise_o,
  output logic                fall_o
);

  logic                   sync_q, filt_q;
  logic [CntWidthMax-1:0] cnt_q;
  logic [CntWidthMax-1:0] len_ext;
  pin_state_t             st_d;

  assign len_ext = CntWidthMax'(len_i);

`ifdef GPIO_FILTER_EDGE_CAPTURE_EN
  logic rise_q, fall_q;
`endif

  always_comb begin
    st_d          = '0;
    st_d.sync     = data_i;
    st_d.filtered = filt_q;
    if (!en_i) begin
      st_d.filtered = sync_q;
    end else if (sync_q != filt_q) begin
      // >= so that lowering L below a running count accepts on the next mismatch
      if (cnt_q >= len_ext) begin
        st_d.filtered = sync_q;
      end else begin
        st_d.cnt = cnt_q + CntWidthMax'(1);
      end
    end
`ifdef GPIO_FILTER_EDGE_CAPTURE_EN
    // Set has priority over a same-edge clear
    st_d.rise = (~filt_q & st_d.filtered) | (rise_q & ~clr_i);
    st_d.fall = (filt_q & ~st_d.filtered) | (fall_q & ~clr_i);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= st_d.sync;
      filt_q <= st_d.filtered;
      cnt_q  <= st_d.cnt;
    end
  end

  assign filtered_o = filt_q;

`ifdef GPIO_FILTER_EDGE_CAPTURE_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= st_d.rise;
      fall_q <= st_d.fall;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  logic unused_flags;
  assign unused_flags = ^{clr_i, st_d.rise, st_d.fall};
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/gpio_in_filter.sv
// Per-pin input conditioning for one GPIO port: 2-flop sync plus debounce filter.
// Define GPIO_FILTER_EDGE_CAPTURE_EN to build the sticky rise/fall flags.
module gpio_in_filter
  import gpio_filter_pkg::*;
#(
  parameter int unsigned IOWidth  = DefIOWidth,
  parameter int unsigned CntWidth = DefCntWidth
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_in_filter_if.slave  gpio
);

  for (genvar i = 0; i < IOWidth; i++) begin : g_pin
    gpio_filter_chan #(
      .CntWidth (CntWidth)
    ) u_chan (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .data_i     (gpio.gpio_in_data[i]),
      .en_i       (gpio.filt_en[i]),
      .len_i      (gpio.filt_len),
      .clr_i      (gpio.flag_clr[i]),
      .filtered_o (gpio.filtered_data[i]),
      .rise_o     (gpio.rise_flags[i]),
      .fall_o     (gpio.fall_flags[i])
    );
  end

endmodule
